// File: rtl/opll_write_sequencer.sv
// Merges memory-mapped and I/O-port OPLL writes into one FIFO and replays them to the
// YM2413 bus, keeping the chip's post-address / post-data busy windows.
module opll_write_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ym_ce,
  input  logic [1:0] opll_wr,
  input  logic       cpu_addr0,
  input  logic [7:0] cpu_din,
  input  logic       io_wr,
  input  logic [7:0] io_addr,
  input  logic [1:0] opll_io_enable,
  output logic       ym_cs_n,
  output logic       ym_we_n,
  output logic       ym_a0,
  output logic [7:0] ym_dout,
  output logic       busy,
  output logic       overflow,
  output logic [4:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

  state_t        state_reg;
  logic [6:0]    count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] level;
  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [8:0]    head;
  logic [8:0]    entry;
  logic          mem_ev;
  logic          io_ev;
  logic          empty;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  assign mem_ev = |opll_wr;
  assign io_ev  = io_wr & (io_addr[7:1] == 7'h3E) & (|opll_io_enable);
  // Memory-mapped source wins a same-cycle collision; the I/O write is lost.
  assign entry  = mem_ev ? {cpu_addr0, cpu_din} : {io_addr[0], cpu_din};

  assign level  = wr_ptr_reg - rd_ptr_reg;
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head   = fifo_mem[rd_ptr_reg[AW-1:0]];

  assign pop    = (state_reg == S_IDLE) && ym_ce && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept = (mem_ev || io_ev) && (!full || pop);
  assign drop   = (mem_ev && io_ev) || ((mem_ev || io_ev) && full && !pop);

  assign busy       = (state_reg != S_IDLE) || (level != '0);
  assign fifo_level = 5'(level);

  always_ff @(posedge clk) begin
    if (accept)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (drop)   overflow   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      ym_cs_n   <= 1'b1;
      ym_we_n   <= 1'b1;
      ym_a0     <= 1'b0;
      ym_dout   <= '0;
    end else if (ym_ce) begin
      case (state_reg)
        S_IDLE: begin
          if (!empty) begin
            ym_cs_n   <= 1'b0;
            ym_we_n   <= 1'b0;
            ym_a0     <= head[8];
            ym_dout   <= head[7:0];
            count_reg <= head[8] ? 7'(DATA_WAIT) : 7'(ADDR_WAIT);
            state_reg <= S_STROBE;
          end
        end
        S_STROBE: begin
          ym_cs_n   <= 1'b1;
          ym_we_n   <= 1'b1;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // Leaving on the tick the count hits zero lets the next pop land one tick later.
          if (count_reg <= 7'd1) begin
            count_reg <= '0;
            state_reg <= S_IDLE;
          end else begin
            count_reg <= count_reg - 7'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/opll_write_sequencer.md
Name: opll_write_sequencer

Overview:
- Responder side of the FM-PAC OPLL write path.
- Collects OPLL register writes from two sources into one FIFO:
  - memory-mapped single-cycle pulses from the two cartridge mapper instances (0x3FF4/0x3FF5);
  - I/O port writes to 0x7C/0x7D, gated by each mapper's OPLL I/O enable.
- Replays the writes to the YM2413 core bus, honouring the chip's post-address and post-data wait times.
- Sits between the slot/cartridge logic and the OPLL sound core.

Parameters:
- FIFO_DEPTH, 8, number of buffered writes (power of two, 2..16).
- ADDR_WAIT, 12, ym_ce ticks after an address write (a0=0) before the next access.
- DATA_WAIT, 84, ym_ce ticks after a data write (a0=1) before the next access.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ym_ce  in  1  OPLL master clock enable, one clk wide.
- opll_wr  in  2  per-cartridge memory-mapped write pulses, one clk wide.
- cpu_addr0  in  1  CPU address bit 0; valid in the opll_wr pulse cycle.
- cpu_din  in  8  CPU write data; valid in the opll_wr or io_wr cycle.
- io_wr  in  1  I/O write strobe, one clk per CPU OUT.
- io_addr  in  8  I/O port address.
- opll_io_enable  in  2  per-cartridge I/O port enable.
- ym_cs_n  out  1  OPLL chip select, active-low.
- ym_we_n  out  1  OPLL write enable, active-low.
- ym_a0  out  1  OPLL address/data select.
- ym_dout  out  8  OPLL write data.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a write was dropped.
- fifo_level  out  5  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - FIFO flushed. FSM goes to IDLE. Wait counter = 0.
  - Outputs: ym_cs_n=1, ym_we_n=1, ym_a0=0, ym_dout=0, busy=0, overflow=0, fifo_level=0.
  - Reset asserted mid-STROBE or mid-WAIT aborts the cycle. Idle bus values appear on the clk edge where reset is sampled.
- Write event sources:
  - mem_ev = |opll_wr; entry {a0=cpu_addr0, d=cpu_din}.
  - io_ev = io_wr & (io_addr[7:1]==7'h3E) & |opll_io_enable; entry {a0=io_addr[0], d=cpu_din}.
  - If both occur in the same clk: mem_ev is enqueued, io_ev is dropped, overflow is set.
- Enqueue:
  - An event cycle N writes the FIFO at edge N; fifo_level reflects it after edge N.
  - Enqueue while full: entry dropped, overflow=1 until reset. This does not apply if a pop occurs in the same cycle; then the entry is accepted and the level is unchanged.
  - Enqueue and pop in the same cycle when not full: level unchanged.
  - No bypass: an entry written at edge N is eligible for pop from cycle N+1 onward.
- FSM (registered outputs):
  - IDLE: when ym_ce=1 and level>0, pop the head entry.
    - Drive ym_cs_n=0, ym_we_n=0, ym_a0=a0, ym_dout=d.
    - Load counter = a0 ? DATA_WAIT : ADDR_WAIT.
    - Go to STROBE.
  - STROBE: held until the next ym_ce=1. On that tick: ym_cs_n=1, ym_we_n=1, go to WAIT. ym_a0 and ym_dout hold their values.
  - WAIT: on each ym_ce=1, decrement the counter. When the counter reaches 0, go to IDLE. The next pop may occur on the following ym_ce tick.
  - Strobe width = exactly 1 ym_ce period.
  - Spacing between consecutive strobe starts = 1 + wait + 1 ym_ce ticks (14 after an address write, 86 after a data write).
- Counter: 7 bits, saturates at 0, never wraps.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; full/empty decided by the MSB comparison.
- busy is combinational: (state != IDLE) | (level != 0).
- ym_ce=0 freezes the FSM and counter. Enqueue is independent of ym_ce.

Test Plan:
- Single address write: opll_wr=01, cpu_addr0=0, cpu_din=0x10 -> strobe a0=0, dout=0x10, 1 ce wide. Next strobe no earlier than 14 ce ticks after the first strobe starts.
- Address/data pair: write 0x30 to a0=0, then 0x55 to a0=1 back-to-back -> two strobes 14 ce apart. busy stays high until 84 ce ticks after the second strobe ends.
- I/O gating:
  - io_wr to port 0x7D, data 0xAA, opll_io_enable=00 -> no enqueue, fifo_level=0.
  - Same write with opll_io_enable=10 -> strobe a0=1, dout=0xAA.
- Overflow: 9 writes in 9 consecutive clk with ym_ce held 0 -> fifo_level=8, overflow=1. The 9th entry is absent when the 8 entries drain in order.
- Collision: opll_wr=10 and a valid io_ev in the same clk -> one entry (memory source data) enqueued, overflow=1.
- Reset mid-WAIT: reset asserted 20 ce ticks into a DATA_WAIT with 3 entries queued -> the next clk shows idle bus values, fifo_level=0, busy=0. No further strobes occur.
